// File: rtl/seg_pkg.sv
// Shared types and glyph constants for the 7-segment capture path.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    WAIT_SEL = 2'd0,
    SETTLE   = 2'd1,
    HOLD     = 2'd2
  } state_e;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_9_ALT = 7'h18;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_B     = 7'h03;
  localparam logic [6:0] GLYPH_C     = 7'h46;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_F     = 7'h0E;

  function automatic logic [2:0] low_count(input logic [NUM_DIGITS-1:0] an_n);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_n[i]) cnt = cnt + 3'd1;
    end
    return cnt;
  endfunction

  function automatic logic [1:0] low_index(input logic [NUM_DIGITS-1:0] an_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_scan_capture_decode.sv
// Combinational active-low segment pattern to hex nibble decoder.
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nib,
  output logic       hit
);

  always_comb begin
    nib = 4'h0;
    hit = 1'b1;
    case (seg_n)
      GLYPH_0:     nib = 4'h0;
      GLYPH_1:     nib = 4'h1;
      GLYPH_2:     nib = 4'h2;
      GLYPH_3:     nib = 4'h3;
      GLYPH_4:     nib = 4'h4;
      GLYPH_5:     nib = 4'h5;
      GLYPH_6:     nib = 4'h6;
      GLYPH_7:     nib = 4'h7;
      GLYPH_8:     nib = 4'h8;
      GLYPH_9:     nib = 4'h9;
      GLYPH_9_ALT: nib = 4'h9;
      GLYPH_A:     nib = 4'hA;
      GLYPH_B:     nib = 4'hB;
      GLYPH_C:     nib = 4'hC;
      GLYPH_D:     nib = 4'hD;
      GLYPH_E:     nib = 4'hE;
      GLYPH_F:     nib = 4'hF;
      default:     hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Decodes a multiplexed 7-segment bus back into a four-digit frame.
// Define SEG_DP_EN to capture decimal points; otherwise dp_n is ignored and dp reads 0.
//
// state    | meaning
// WAIT_SEL | bus blanked (an_n all ones), nothing to capture
// SETTLE   | digit selected, waiting for SETTLE_CYCLES stable samples
// HOLD     | digit captured, waiting for the bus to move on
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an_n,
  input  logic [6:0]  seg_n,
  input  logic        dp_n,
  input  logic        err_clr,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic        valid,
  output logic        frame_done,
  output logic        sel_err,
  output logic        seg_err
);

  localparam logic [3:0]  SETTLE_W  = 4'(SETTLE_CYCLES);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
  localparam int          IN_W      = 12;

  logic              dp_eff_n;
  logic [IN_W-1:0]   in_cur;
  logic [IN_W-1:0]   prev_q, prev_d;
  logic [3:0]        stable_q, stable_d;
  state_e            state_q, state_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [15:0]       shadow_q, shadow_d;
  logic [3:0]        shadow_dp_q, shadow_dp_d;
  logic [3:0]        mask_q, mask_d;
  logic [15:0]       digits_q, digits_d;
  logic [3:0]        dp_q, dp_d;
  logic              valid_q, valid_d;
  logic              frame_done_q, frame_done_d;
  logic              sel_err_q, sel_err_d;
  logic              seg_err_q, seg_err_d;

  logic              changed;
  logic              blank;
  logic              capture;
  logic              multi_sel;
  logic              cap_ok;
  logic              complete;
  logic              tmo_expire;
  logic [1:0]        cap_idx;
  logic [3:0]        dec_nib;
  logic              dec_hit;

`ifdef SEG_DP_EN
  assign dp_eff_n = dp_n;
`else
  // Tying the dp bit high keeps it out of the stability compare and the shadow.
  logic dp_n_unused;
  assign dp_n_unused = dp_n;
  assign dp_eff_n    = 1'b1;
`endif

  assign in_cur  = {an_n, seg_n, dp_eff_n};
  assign changed = (in_cur != prev_q);
  assign blank   = &an_n;

  seg_decode u_decode (
    .seg_n (seg_n),
    .nib   (dec_nib),
    .hit   (dec_hit)
  );

  always_comb begin
    prev_d   = in_cur;
    stable_d = stable_q;
    if (changed) begin
      stable_d = 4'd0;
    end else if (stable_q != SETTLE_W) begin
      stable_d = stable_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      WAIT_SEL: begin
        if (!blank) state_d = SETTLE;
      end
      SETTLE: begin
        if (blank) begin
          state_d = WAIT_SEL;
        end else if (stable_d == SETTLE_W) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (changed) state_d = blank ? WAIT_SEL : SETTLE;
      end
      default: state_d = WAIT_SEL;
    endcase
  end

  assign multi_sel  = (low_count(an_n) > 3'd1);
  assign cap_idx    = low_index(an_n);
  assign cap_ok     = capture && !multi_sel && dec_hit;
  // A full mask is only ever seen for the one cycle after the final capture.
  assign complete   = (mask_q == 4'hF);
  assign tmo_expire = !capture && (tmo_q == 16'd1);

  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    mask_d      = mask_q;
    if (complete || tmo_expire) mask_d = 4'h0;
    if (cap_ok) begin
      shadow_d[{cap_idx, 2'b00} +: 4] = dec_nib;
      shadow_dp_d[cap_idx]            = ~dp_eff_n;
      mask_d[cap_idx]                 = 1'b1;
    end
  end

  always_comb begin
    tmo_d = tmo_q;
    if (capture) begin
      tmo_d = TIMEOUT_W;
    end else if (tmo_q != 16'd0) begin
      tmo_d = tmo_q - 16'd1;
    end
  end

  always_comb begin
    digits_d     = digits_q;
    dp_d         = dp_q;
    valid_d      = valid_q;
    frame_done_d = complete;
    if (complete) begin
      digits_d = shadow_q;
      dp_d     = shadow_dp_q;
      valid_d  = 1'b1;
    end
    if (tmo_expire) valid_d = 1'b0;
  end

  // A new error on the clearing edge takes precedence over err_clr.
  always_comb begin
    sel_err_d = (sel_err_q && !err_clr) || (capture && multi_sel);
    seg_err_d = (seg_err_q && !err_clr) || (capture && !multi_sel && !dec_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q       <= '0;
      stable_q     <= 4'd0;
      state_q      <= WAIT_SEL;
      tmo_q        <= 16'd0;
      shadow_q     <= 16'h0;
      shadow_dp_q  <= 4'h0;
      mask_q       <= 4'h0;
      digits_q     <= 16'h0;
      dp_q         <= 4'h0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      sel_err_q    <= 1'b0;
      seg_err_q    <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      stable_q     <= stable_d;
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      mask_q       <= mask_d;
      digits_q     <= digits_d;
      dp_q         <= dp_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      sel_err_q    <= sel_err_d;
      seg_err_q    <= seg_err_d;
    end
  end

  assign digits     = digits_q;
  assign dp         = dp_q;
  assign valid      = valid_q;
  assign frame_done = frame_done_q;
  assign sel_err    = sel_err_q;
  assign seg_err    = seg_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed self-checking bench for seg_scan_capture (SETTLE_CYCLES=2, TIMEOUT=40).
module tb_seg_scan_capture;

  localparam int SETTLE = 2;
  localparam int TMO    = 40;

  logic        clk;
  logic        rst;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        err_clr;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        valid;
  logic        frame_done;
  logic        sel_err;
  logic        seg_err;

  int total;
  int bad;
  int fd_count;

  seg_scan_capture #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT       (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .err_clr    (err_clr),
    .digits     (digits),
    .dp         (dp),
    .valid      (valid),
    .frame_done (frame_done),
    .sel_err    (sel_err),
    .seg_err    (seg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_count = fd_count + 1;
  end

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input logic dpn, input int n);
    an_n  = an;
    seg_n = seg;
    dp_n  = dpn;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    an_n  = 4'hF;
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (digits !== 16'h0) begin bad++; $display("FAIL reset_digits got=%h exp=%h", digits, 16'h0); end
    total++; if (dp !== 4'h0) begin bad++; $display("FAIL reset_dp got=%b exp=%b", dp, 4'h0); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL reset_sel_err got=%b exp=0", sel_err); end
    total++; if (seg_err !== 1'b0) begin bad++; $display("FAIL reset_seg_err got=%b exp=0", seg_err); end
  endtask

  task automatic test_short_hold();
    int fd0;
    fd0 = fd_count;
    hold(4'hF, 7'h7F, 1'b1, 2);
    hold(4'b1110, 7'h06, 1'b1, 2);
    hold(4'b1101, 7'h0E, 1'b1, 2);
    hold(4'b1011, 7'h10, 1'b1, 2);
    hold(4'b0111, 7'h21, 1'b1, 2);
    hold(4'hF, 7'h7F, 1'b1, 3);
    total++; if (fd_count - fd0 !== 0) begin bad++; $display("FAIL short_frames got=%0d exp=0", fd_count - fd0); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL short_valid got=%b exp=0", valid); end
    total++; if (digits !== 16'h0) begin bad++; $display("FAIL short_digits got=%h exp=%h", digits, 16'h0); end
  endtask

  task automatic test_scan();
    int fd0;
    logic [3:0] exp_dp;
`ifdef SEG_DP_EN
    exp_dp = 4'b1010;
`else
    exp_dp = 4'b0000;
`endif
    fd0 = fd_count;
    hold(4'hF, 7'h7F, 1'b1, 2);
    hold(4'b1110, 7'h79, 1'b1, 4);
    hold(4'b1101, 7'h24, 1'b0, 4);
    hold(4'b1011, 7'h30, 1'b1, 4);
    hold(4'b0111, 7'h40, 1'b0, 3);
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL scan_early_done got=%b exp=0", frame_done); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL scan_early_valid got=%b exp=0", valid); end
    hold(4'b0111, 7'h40, 1'b0, 1);
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL scan_done_pulse got=%b exp=1", frame_done); end
    total++; if (digits !== 16'h0321) begin bad++; $display("FAIL scan_digits got=%h exp=%h", digits, 16'h0321); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL scan_valid got=%b exp=1", valid); end
    total++; if (dp !== exp_dp) begin bad++; $display("FAIL scan_dp got=%b exp=%b", dp, exp_dp); end
    hold(4'hF, 7'h7F, 1'b1, 1);
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL scan_done_width got=%b exp=0", frame_done); end
    hold(4'hF, 7'h7F, 1'b1, 3);
    total++; if (fd_count - fd0 !== 1) begin bad++; $display("FAIL scan_frames got=%0d exp=1", fd_count - fd0); end
  endtask

  task automatic test_timeout();
    hold(4'hF, 7'h7F, 1'b1, 2);
    hold(4'b1110, 7'h08, 1'b1, 4);
    hold(4'b1101, 7'h03, 1'b1, 4);
    hold(4'b1011, 7'h46, 1'b1, 4);
    hold(4'b0111, 7'h21, 1'b1, 3);
    hold(4'hF, 7'h7F, 1'b1, TMO - 1);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL tmo_before got=%b exp=1", valid); end
    total++; if (digits !== 16'hDCBA) begin bad++; $display("FAIL tmo_frame got=%h exp=%h", digits, 16'hDCBA); end
    hold(4'hF, 7'h7F, 1'b1, 1);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL tmo_at got=%b exp=0", valid); end
    total++; if (digits !== 16'hDCBA) begin bad++; $display("FAIL tmo_retain got=%h exp=%h", digits, 16'hDCBA); end
  endtask

  task automatic test_sel_err();
    int fd0;
    fd0 = fd_count;
    hold(4'hF, 7'h7F, 1'b1, 2);
    hold(4'b1100, 7'h79, 1'b1, 4);
    total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL sel_set got=%b exp=1", sel_err); end
    total++; if (seg_err !== 1'b0) begin bad++; $display("FAIL sel_no_seg got=%b exp=0", seg_err); end
    hold(4'hF, 7'h7F, 1'b1, 2);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL sel_clear got=%b exp=0", sel_err); end
    hold(4'b1001, 7'h30, 1'b1, 2);
    err_clr = 1'b1;
    hold(4'b1001, 7'h30, 1'b1, 1);
    err_clr = 1'b0;
    total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL sel_err_wins got=%b exp=1", sel_err); end
    hold(4'hF, 7'h7F, 1'b1, 2);
    total++; if (fd_count - fd0 !== 0) begin bad++; $display("FAIL sel_frames got=%0d exp=0", fd_count - fd0); end
    total++; if (digits !== 16'hDCBA) begin bad++; $display("FAIL sel_digits got=%h exp=%h", digits, 16'hDCBA); end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic test_seg_err();
    int fd0;
    do_reset();
    fd0 = fd_count;
    hold(4'hF, 7'h7F, 1'b1, 2);
    hold(4'b1110, 7'h00, 1'b1, 4);
    hold(4'b1101, 7'h18, 1'b1, 4);
    hold(4'b1011, 7'h7F, 1'b1, 4);
    total++; if (seg_err !== 1'b1) begin bad++; $display("FAIL seg_set got=%b exp=1", seg_err); end
    hold(4'b0111, 7'h78, 1'b1, 4);
    total++; if (fd_count - fd0 !== 0) begin bad++; $display("FAIL seg_no_frame got=%0d exp=0", fd_count - fd0); end
    hold(4'b1011, 7'h12, 1'b1, 4);
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL seg_recap_done got=%b exp=1", frame_done); end
    total++; if (digits !== 16'h7598) begin bad++; $display("FAIL seg_recap_digits got=%h exp=%h", digits, 16'h7598); end
    total++; if (seg_err !== 1'b1) begin bad++; $display("FAIL seg_sticky got=%b exp=1", seg_err); end
    hold(4'hF, 7'h7F, 1'b1, 2);
  endtask

  task automatic test_reset_mid_frame();
    int fd0;
    do_reset();
    fd0 = fd_count;
    hold(4'hF, 7'h7F, 1'b1, 2);
    hold(4'b1110, 7'h10, 1'b1, 4);
    hold(4'b1101, 7'h06, 1'b1, 4);
    hold(4'b1011, 7'h0E, 1'b1, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold(4'b0111, 7'h40, 1'b1, 4);
    hold(4'hF, 7'h7F, 1'b1, 3);
    total++; if (fd_count - fd0 !== 0) begin bad++; $display("FAIL rmid_frames got=%0d exp=0", fd_count - fd0); end
    total++; if (digits !== 16'h0) begin bad++; $display("FAIL rmid_digits got=%h exp=%h", digits, 16'h0); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", valid); end
    total++; if (dp !== 4'h0) begin bad++; $display("FAIL rmid_dp got=%b exp=0000", dp); end
    total++; if (sel_err !== 1'b0 || seg_err !== 1'b0) begin bad++; $display("FAIL rmid_errs got=%b%b exp=00", sel_err, seg_err); end
    hold(4'b1110, 7'h40, 1'b1, 4);
    hold(4'b1101, 7'h79, 1'b1, 4);
    hold(4'b1011, 7'h24, 1'b1, 4);
    hold(4'hF, 7'h7F, 1'b1, 2);
    total++; if (fd_count - fd0 !== 1) begin bad++; $display("FAIL rmid_refill_frames got=%0d exp=1", fd_count - fd0); end
    total++; if (digits !== 16'h0210) begin bad++; $display("FAIL rmid_refill_digits got=%h exp=%h", digits, 16'h0210); end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    fd_count = 0;
    rst      = 1'b1;
    an_n     = 4'hF;
    seg_n    = 7'h7F;
    dp_n     = 1'b1;
    err_clr  = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_short_hold();
    test_scan();
    test_timeout();
    test_sel_err();
    test_seg_err();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receiving end of the multiplexed 7-segment display bus. Watches the active-low digit-select and segment lines produced by the display scanner and decodes each lit digit back to a hex nibble. Delivers a coherent four-digit frame with a completion pulse. Used in on-board loopback self-test and as the bench-side checker for the display path. Inputs are in the `clk` domain, so no synchronizers are needed.

## Interface
- `SETTLE_CYCLES`, default 2: consecutive rising edges an input value must be re-sampled unchanged before it is captured; range 1–15.
- `TIMEOUT`, default 1024: cycles without a capture before `valid` drops; range 2–65535.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `an_n` in 4: digit select, active-low one-hot; bit0 low means digit 0.
- `seg_n` in 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp_n` in 1: decimal point, active-low.
- `err_clr` in 1: single-cycle clear of the sticky error flags.
- `digits` out 16: last complete frame, {d3,d2,d1,d0}.
- `dp` out 4: decimal point per digit in the last frame, active-high.
- `valid` out 1: `digits` holds a frame that has not timed out.
- `frame_done` out 1: one-cycle pulse when `digits` updates.
- `sel_err` out 1: sticky; more than one `an_n` bit was low at a capture.
- `seg_err` out 1: sticky; the captured segment pattern is not a hex glyph.

## Operation
- Reset values:
  - `digits` = 0, `dp` = 0.
  - `valid`, `frame_done`, `sel_err`, `seg_err` = 0.
  - Internal: shadow = 0, seen mask = 0, FSM = WAIT_SEL, stable count = 0, timeout count = 0.
- Input register `prev` holds {`an_n`, `seg_n`, `dp_n`} from the previous edge.
  - The stable count resets to 0 when the current input differs from `prev`.
  - Otherwise it increments, saturating at SETTLE_CYCLES.
- FSM states:
  - WAIT_SEL: `an_n` == 4'b1111 (blanking). No capture and no error. Leave when any bit goes low.
  - SETTLE: count the stable cycles. When the stable count reaches SETTLE_CYCLES, perform the capture and go to HOLD.
  - HOLD: one capture per stable interval. Any input change returns to SETTLE, or to WAIT_SEL if `an_n` is all ones.
- Capture rules:
  - Exactly one `an_n` bit low:
    - Decode `seg_n` into a shadow nibble at that index.
    - Store `~dp_n` into the shadow dp bit.
    - Set that index's bit in the seen mask.
  - More than one `an_n` bit low: set `sel_err`; shadow and mask unchanged.
  - Undecodable segment pattern: set `seg_err`; the shadow digit keeps its old value and the mask bit is not set.
- Decode table, active-low `seg_n`: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex). Both 9=10 and 9=18 are accepted.
- Frame completion: when a capture makes the seen mask 4'b1111:
  - Next edge: `digits` ← shadow, `dp` ← shadow dp, `valid` ← 1, `frame_done` pulses, mask ← 0.
  - Re-capturing a digit already in the mask overwrites the shadow and does not complete a frame.
- Timeout:
  - The counter clears on every capture.
  - On reaching TIMEOUT: `valid` ← 0, mask ← 0, counter holds.
  - `digits` is retained.
- Errors:
  - `err_clr` clears both flags.
  - If `err_clr` and a new error occur on the same edge, the error wins and the flag stays set.
- Reset mid-frame discards the shadow and the mask.

## Timing
- Input change seen at edge k: the capture happens at edge k+SETTLE_CYCLES.
- With SETTLE_CYCLES=2, a digit must be held at least 3 cycles to be captured.
- The last digit's capture is at edge c; `digits`, `valid` and `frame_done` update at edge c+1.
- `frame_done` is high for exactly one cycle; back-to-back frames are at least 4×(SETTLE_CYCLES+1) cycles apart.
- All outputs are registered.

## Configuration
- `SEG_DP_EN`:
  - Defined: decimal points are captured and reported on `dp`.
  - Undefined: `dp_n` is ignored, `dp` is constant 4'b0000, and the dp bit is excluded from the stability compare.

## Structure
- Package `seg_pkg`:
  - FSM state enum (WAIT_SEL, SETTLE, HOLD).
  - Glyph constants for the 16 hex digits.
  - Digit-count constant NUM_DIGITS = 4.
- Sub-module `seg_decode`:
  - Combinational: 7-bit active-low pattern in; 4-bit nibble and `hit` out.
  - Shareable with a future encoder-side check.

## Test plan
- Scan `an_n` 1110/1101/1011/0111 with `seg_n` 79/24/30/40, each held 4 cycles, SETTLE_CYCLES=2 -> one `frame_done` pulse; `digits`=16'h0321, `valid`=1.
- Hold each digit only 2 cycles at SETTLE_CYCLES=2 -> no capture, no `frame_done`, `valid` stays 0.
- `an_n`=4'b1100 held 4 cycles -> `sel_err`=1, no frame. Then `err_clr` for 1 cycle -> `sel_err`=0.
- `seg_n`=7'h7F (all off) on digit 2 -> `seg_err`=1; the frame completes only after digit 2 is recaptured with a valid glyph.
- After a valid frame, hold `an_n`=1111 for TIMEOUT cycles -> `valid` falls at exactly TIMEOUT; `digits` unchanged.
- Assert `rst` after 3 digits are captured, then send digit 3 only -> no `frame_done`; all outputs at reset values.
